// File: rtl/line_buffer_11rows_pkg.sv
// line_buffer_11rows_pkg: constants shared by the row aligner and the window buffer it feeds.
package line_buffer_11rows_pkg;
    localparam int WIN_SIZE = 11;
    localparam int LINES = WIN_SIZE - 1;
    localparam int PIX_W = 8;
    localparam int CNT_W = 10;
endpackage

// File: rtl/line_buffer_11rows_if.sv
// line_buffer_11rows_if: raster pixel stream in, aligned 11-row column taps out.
interface line_buffer_11rows_if #(parameter int PIX_W = line_buffer_11rows_pkg::PIX_W);
    import line_buffer_11rows_pkg::*;
    logic [PIX_W-1:0] data_i;
    logic valid_i;
    logic [PIX_W-1:0] S1_o, S2_o, S3_o, S4_o, S5_o, S6_o, S7_o, S8_o, S9_o, S10_o, S11_o;
    logic valid_o;
    logic frame_done_o;
    logic [CNT_W-1:0] row_o, col_o;
    modport master (
        output data_i, valid_i,
        input S1_o, S2_o, S3_o, S4_o, S5_o, S6_o, S7_o, S8_o, S9_o, S10_o, S11_o,
        input valid_o, frame_done_o, row_o, col_o
    );
    modport slave (
        input data_i, valid_i,
        output S1_o, S2_o, S3_o, S4_o, S5_o, S6_o, S7_o, S8_o, S9_o, S10_o, S11_o,
        output valid_o, frame_done_o, row_o, col_o
    );
endinterface

// File: rtl/line_buffer_11rows_line_fifo_ram.sv
// line_fifo_ram: one image row of storage; combinational read returns the pre-write word.
module line_fifo_ram #(
    parameter int DEPTH = 9,
    parameter int WIDTH = 8,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] mem [DEPTH];
    assign q = mem[addr];
    always_ff @(posedge clk)
        if (we) mem[addr] <= d;
endmodule

// File: rtl/line_buffer_11rows.sv
// line_buffer_11rows: chains 10 line FIFOs so each accepted pixel yields its column
// across the 11 most recent rows, valid once 10 rows of the current frame are stored.
module line_buffer_11rows #(
    parameter int COLS = 9,
    parameter int ROWS = 9,
    parameter int PIX_W = line_buffer_11rows_pkg::PIX_W
) (
    input logic clk,
    input logic rst,
    line_buffer_11rows_if.slave bus
);
    import line_buffer_11rows_pkg::*;
    localparam int AW = $clog2(COLS);
    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(COLS - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(ROWS - 1);
    logic [CNT_W-1:0] col_cnt, row_cnt, row_q, col_q;
    logic [PIX_W-1:0] q [LINES];
    logic [PIX_W-1:0] tap_d [WIN_SIZE];
    logic [PIX_W-1:0] taps [WIN_SIZE];
    logic valid_q, done_q;
    logic col_last, row_last;
    assign col_last = col_cnt == COL_LAST;
    assign row_last = row_cnt == ROW_LAST;
    // line[k] takes the word line[k-1] held at this column, so rows ripple down one FIFO per frame row
    for (genvar k = 0; k < LINES; k++) begin : g_line
        if (k == 0) begin : g_head
            line_fifo_ram #(.DEPTH(COLS), .WIDTH(PIX_W)) u_ram (
                .clk(clk), .we(bus.valid_i), .addr(col_cnt[AW-1:0]), .d(bus.data_i), .q(q[k])
            );
        end else begin : g_tail
            line_fifo_ram #(.DEPTH(COLS), .WIDTH(PIX_W)) u_ram (
                .clk(clk), .we(bus.valid_i), .addr(col_cnt[AW-1:0]), .d(q[k-1]), .q(q[k])
            );
        end
    end
    always_comb begin
        tap_d[WIN_SIZE-1] = bus.data_i;
        for (int j = 0; j < LINES; j++) tap_d[j] = q[LINES-1-j];
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
            row_q <= '0;
            col_q <= '0;
            valid_q <= 1'b0;
            done_q <= 1'b0;
            taps <= '{default: '0};
        end else begin
            valid_q <= bus.valid_i && row_cnt >= CNT_W'(LINES);
            done_q <= bus.valid_i && col_last && row_last;
            if (bus.valid_i) begin
                col_cnt <= col_last ? '0 : col_cnt + 1'b1;
                if (col_last) row_cnt <= row_last ? '0 : row_cnt + 1'b1;
                row_q <= row_cnt;
                col_q <= col_cnt;
                taps <= tap_d;
            end
        end
    assign bus.valid_o = valid_q;
    assign bus.frame_done_o = done_q;
    assign bus.row_o = row_q;
    assign bus.col_o = col_q;
    assign bus.S1_o = taps[0];
    assign bus.S2_o = taps[1];
    assign bus.S3_o = taps[2];
    assign bus.S4_o = taps[3];
    assign bus.S5_o = taps[4];
    assign bus.S6_o = taps[5];
    assign bus.S7_o = taps[6];
    assign bus.S8_o = taps[7];
    assign bus.S9_o = taps[8];
    assign bus.S10_o = taps[9];
    assign bus.S11_o = taps[10];
endmodule

// File: tb/tb_line_buffer_11rows.sv
// tb_line_buffer_11rows: directed checks of the 11-row aligner on a 16x16 frame, pixel = 16*r + c.
module tb_line_buffer_11rows;
    localparam int COLS = 16;
    localparam int ROWS = 16;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [7:0] s [11];
    logic [7:0] prev [11];
    logic [7:0] win [11][11];
    always #5 clk = ~clk;
    line_buffer_11rows_if #(.PIX_W(8)) bus ();
    line_buffer_11rows #(.COLS(COLS), .ROWS(ROWS), .PIX_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign s[0] = bus.S1_o;
    assign s[1] = bus.S2_o;
    assign s[2] = bus.S3_o;
    assign s[3] = bus.S4_o;
    assign s[4] = bus.S5_o;
    assign s[5] = bus.S6_o;
    assign s[6] = bus.S7_o;
    assign s[7] = bus.S8_o;
    assign s[8] = bus.S9_o;
    assign s[9] = bus.S10_o;
    assign s[10] = bus.S11_o;
    function automatic logic [7:0] pix(int r, int c);
        return 8'((16 * r + c) % 256);
    endfunction
    task automatic step(input logic v, input logic [7:0] d);
        bus.valid_i = v;
        bus.data_i = d;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        bus.valid_i = 1'b0;
        bus.data_i = 8'h00;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks += 4;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.valid_o); end
        if (bus.frame_done_o !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.frame_done_o); end
        if (bus.row_o !== 10'd0) begin errors++; $display("FAIL reset_row got %0d exp 0", bus.row_o); end
        if (bus.col_o !== 10'd0) begin errors++; $display("FAIL reset_col got %0d exp 0", bus.col_o); end
        for (int j = 0; j < 11; j++) begin
            checks++;
            if (s[j] !== 8'h00) begin errors++; $display("FAIL reset_S%0d got %h exp 00", j + 1, s[j]); end
        end
        rst = 1'b1;
    endtask
    task automatic test_frame;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                step(1'b1, pix(r, c));
                checks += 4;
                if (bus.valid_o !== (r >= 10)) begin errors++; $display("FAIL frame_valid r=%0d c=%0d got %b exp %b", r, c, bus.valid_o, r >= 10); end
                if (bus.row_o !== 10'(r)) begin errors++; $display("FAIL frame_row r=%0d c=%0d got %0d", r, c, bus.row_o); end
                if (bus.col_o !== 10'(c)) begin errors++; $display("FAIL frame_col r=%0d c=%0d got %0d", r, c, bus.col_o); end
                if (bus.frame_done_o !== (r == 15 && c == 15)) begin errors++; $display("FAIL frame_done r=%0d c=%0d got %b", r, c, bus.frame_done_o); end
                if (r >= 10)
                    for (int j = 0; j < 11; j++) begin
                        checks++;
                        if (s[j] !== pix(r - 10 + j, c)) begin errors++; $display("FAIL frame_S%0d r=%0d c=%0d got %h exp %h", j + 1, r, c, s[j], pix(r - 10 + j, c)); end
                    end
                if (r == 10 && c == 0) begin
                    checks += 3;
                    if (s[10] !== 8'hA0) begin errors++; $display("FAIL first_S11 got %h exp a0", s[10]); end
                    if (s[9] !== 8'h90) begin errors++; $display("FAIL first_S10 got %h exp 90", s[9]); end
                    if (s[0] !== 8'h00) begin errors++; $display("FAIL first_S1 got %h exp 00", s[0]); end
                end
                if (r == 15 && c == 15) begin
                    checks += 2;
                    if (s[10] !== 8'hFF) begin errors++; $display("FAIL last_S11 got %h exp ff", s[10]); end
                    if (s[0] !== 8'h5F) begin errors++; $display("FAIL last_S1 got %h exp 5f", s[0]); end
                end
            end
        step(1'b0, 8'h55);
        checks += 3;
        if (bus.frame_done_o !== 1'b0) begin errors++; $display("FAIL done_pulse got %b exp 0", bus.frame_done_o); end
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL idle_valid got %b exp 0", bus.valid_o); end
        if (s[10] !== 8'hFF) begin errors++; $display("FAIL idle_hold_S11 got %h exp ff", s[10]); end
    endtask
    task automatic test_back_to_back;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                step(1'b1, pix(r, c));
                checks++;
                if (bus.valid_o !== (r >= 10)) begin errors++; $display("FAIL b2b_valid r=%0d c=%0d got %b exp %b", r, c, bus.valid_o, r >= 10); end
                if (r >= 10) begin
                    checks++;
                    if (s[0] !== pix(r - 10, c)) begin errors++; $display("FAIL b2b_S1 r=%0d c=%0d got %h exp %h", r, c, s[0], pix(r - 10, c)); end
                end
                if (r == 10 && c == 0) begin
                    checks++;
                    if (s[10] !== 8'hA0) begin errors++; $display("FAIL b2b_S11 got %h exp a0", s[10]); end
                end
                if (r == 15 && c == 15) begin
                    checks++;
                    if (bus.frame_done_o !== 1'b1) begin errors++; $display("FAIL b2b_done got %b exp 1", bus.frame_done_o); end
                end
            end
    endtask
    task automatic test_gaps;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                for (int g = 0; g < 3 && $urandom_range(0, 99) < 40; g++) begin
                    prev = s;
                    step(1'b0, 8'($urandom));
                    checks += 2;
                    if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL gap_valid r=%0d c=%0d got %b exp 0", r, c, bus.valid_o); end
                    if (bus.frame_done_o !== 1'b0) begin errors++; $display("FAIL gap_done r=%0d c=%0d got %b exp 0", r, c, bus.frame_done_o); end
                    for (int j = 0; j < 11; j++) begin
                        checks++;
                        if (s[j] !== prev[j]) begin errors++; $display("FAIL gap_hold_S%0d r=%0d c=%0d got %h exp %h", j + 1, r, c, s[j], prev[j]); end
                    end
                end
                step(1'b1, pix(r, c));
                checks += 2;
                if (bus.valid_o !== (r >= 10)) begin errors++; $display("FAIL gaps_valid r=%0d c=%0d got %b exp %b", r, c, bus.valid_o, r >= 10); end
                if (bus.frame_done_o !== (r == 15 && c == 15)) begin errors++; $display("FAIL gaps_done r=%0d c=%0d got %b", r, c, bus.frame_done_o); end
                if (r >= 10)
                    for (int j = 0; j < 11; j++) begin
                        checks++;
                        if (s[j] !== pix(r - 10 + j, c)) begin errors++; $display("FAIL gaps_S%0d r=%0d c=%0d got %h exp %h", j + 1, r, c, s[j], pix(r - 10 + j, c)); end
                    end
            end
    endtask
    task automatic test_reset_mid;
        for (int r = 0; r <= 12; r++)
            for (int c = 0; c < (r == 12 ? 5 : COLS); c++) step(1'b1, pix(r, c));
        checks++;
        if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got %b exp 1", bus.valid_o); end
        bus.valid_i = 1'b0;
        rst = 1'b0;
        #1;
        checks += 4;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL mid_reset_valid got %b exp 0", bus.valid_o); end
        if (bus.row_o !== 10'd0) begin errors++; $display("FAIL mid_reset_row got %0d exp 0", bus.row_o); end
        if (bus.col_o !== 10'd0) begin errors++; $display("FAIL mid_reset_col got %0d exp 0", bus.col_o); end
        if (s[10] !== 8'h00) begin errors++; $display("FAIL mid_reset_S11 got %h exp 00", s[10]); end
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int r = 0; r <= 10; r++)
            for (int c = 0; c < COLS; c++) begin
                step(1'b1, pix(r, c));
                checks += 3;
                if (bus.valid_o !== (r >= 10)) begin errors++; $display("FAIL post_reset_valid r=%0d c=%0d got %b exp %b", r, c, bus.valid_o, r >= 10); end
                if (bus.row_o !== 10'(r)) begin errors++; $display("FAIL post_reset_row r=%0d c=%0d got %0d", r, c, bus.row_o); end
                if (bus.col_o !== 10'(c)) begin errors++; $display("FAIL post_reset_col r=%0d c=%0d got %0d", r, c, bus.col_o); end
                if (r == 10 && c == 0) begin
                    checks += 2;
                    if (s[10] !== 8'hA0) begin errors++; $display("FAIL post_reset_S11 got %h exp a0", s[10]); end
                    if (s[0] !== 8'h00) begin errors++; $display("FAIL post_reset_S1 got %h exp 00", s[0]); end
                end
            end
    endtask
    task automatic test_window;
        int n;
        n = 0;
        bus.valid_i = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int r = 0; r <= 10; r++)
            for (int c = 0; c < COLS; c++) begin
                step(1'b1, pix(r, c));
                if (bus.valid_o === 1'b1 && n < 11) begin
                    for (int j = 0; j < 11; j++) win[j][n] = s[j];
                    n++;
                end
            end
        checks += 5;
        if (n !== 11) begin errors++; $display("FAIL win_columns got %0d exp 11", n); end
        if (win[0][0] !== 8'h00) begin errors++; $display("FAIL win_top_left got %h exp 00", win[0][0]); end
        if (win[10][10] !== 8'hAA) begin errors++; $display("FAIL win_bottom_right got %h exp aa", win[10][10]); end
        if (win[0][10] !== 8'h0A) begin errors++; $display("FAIL win_top_right got %h exp 0a", win[0][10]); end
        if (win[10][0] !== 8'hA0) begin errors++; $display("FAIL win_bottom_left got %h exp a0", win[10][0]); end
    endtask
    initial begin
        test_reset;
        test_frame;
        test_back_to_back;
        test_gaps;
        test_reset_mid;
        test_window;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
